// File: rtl/vp8_tx_pkg.sv
// Shared VP8 4x4 transform constants, fixed-point multiply, clip and block packing helpers.
// Widths are sized so that no intermediate value of the inverse transform can wrap.
package vp8_tx_pkg;

   localparam int DEF_COEF_W = 16;
   localparam int TMP_W      = DEF_COEF_W + 3;
   localparam int SUM_W      = DEF_COEF_W + 4;
   localparam int ACC_W      = TMP_W + 3;
   localparam int K_W        = 18;
   localparam int PROD_W     = TMP_W + K_W;
   localparam int MUL_W      = PROD_W - 16;
   localparam int PIX_W      = 8;
   localparam int NPIX       = 16;
   localparam int BLK_PIX_W  = NPIX * PIX_W;
   localparam int BLK_COEF_W = NPIX * DEF_COEF_W;

   // K1 carries the implicit +1.0 so a single multiply gives x*sqrt(2)*cos(pi/8)
   localparam logic signed [K_W-1:0] K1 = 18'sd85627;
   localparam logic signed [K_W-1:0] K2 = 18'sd35468;

   function automatic logic signed [MUL_W-1:0] mul(input logic signed [TMP_W-1:0] x,
                                                    input logic signed [K_W-1:0]   k);
      logic signed [PROD_W-1:0] p;
      p = PROD_W'(x) * PROD_W'(k);
      return p[PROD_W-1:16];
   endfunction

   function automatic logic [PIX_W-1:0] clip255(input logic signed [SUM_W-1:0] s);
      if (s < 0)
         return 8'd0;
      else if (s > 255)
         return 8'hff;
      else
         return s[PIX_W-1:0];
   endfunction

   function automatic logic signed [DEF_COEF_W-1:0] coef_at(input logic [BLK_COEF_W-1:0] blk,
                                                            input int k);
      return blk[DEF_COEF_W*k +: DEF_COEF_W];
   endfunction

   function automatic logic [PIX_W-1:0] pix_at(input logic [BLK_PIX_W-1:0] blk, input int k);
      return blk[PIX_W*k +: PIX_W];
   endfunction

endpackage

// File: rtl/itransform_4x4_if.sv
// Block stream bundle: coef/pred in with valid/ready, reconstructed pixels out with valid/ready.
// slave is the transform side, master is the producer/consumer side.
interface itransform_4x4_if
   import vp8_tx_pkg::*;
#(
   parameter int COEF_W = DEF_COEF_W
);
   logic                  in_valid;
   logic                  in_ready;
   logic [16*COEF_W-1:0]  coef;
   logic [BLK_PIX_W-1:0]  pred;
   logic                  out_valid;
   logic                  out_ready;
   logic [BLK_PIX_W-1:0]  recon;

   modport master (
      output in_valid, coef, pred, out_ready,
      input  in_ready, out_valid, recon
   );

   modport slave (
      input  in_valid, coef, pred, out_ready,
      output in_ready, out_valid, recon
   );
endinterface

// File: rtl/itransform_4x4_idct_1d.sv
// Combinational 4-point VP8 inverse butterfly; dc_bias is folded into the even terms (4 gives the
// rounding offset for the final >>3 in the horizontal pass, 0 in the vertical pass).
module idct_1d
   import vp8_tx_pkg::*;
#(
   parameter int IN_W  = DEF_COEF_W,
   parameter int OUT_W = TMP_W
) (
   input  logic signed [IN_W-1:0]  in0,
   input  logic signed [IN_W-1:0]  in1,
   input  logic signed [IN_W-1:0]  in2,
   input  logic signed [IN_W-1:0]  in3,
   input  logic        [2:0]       dc_bias,
   output logic signed [OUT_W-1:0] out0,
   output logic signed [OUT_W-1:0] out1,
   output logic signed [OUT_W-1:0] out2,
   output logic signed [OUT_W-1:0] out3
);
   logic signed [ACC_W-1:0] x0, x2, bias;
   logic signed [ACC_W-1:0] a, b, cc, d;
   logic signed [ACC_W-1:0] s0, s1, s2, s3;

   assign x0   = ACC_W'(in0);
   assign x2   = ACC_W'(in2);
   assign bias = ACC_W'($signed({1'b0, dc_bias}));

   assign a  = x0 + bias + x2;
   assign b  = x0 + bias - x2;
   assign cc = ACC_W'(mul(TMP_W'(in1), K2)) - ACC_W'(mul(TMP_W'(in3), K1));
   assign d  = ACC_W'(mul(TMP_W'(in1), K1)) + ACC_W'(mul(TMP_W'(in3), K2));

   assign s0 = a + d;
   assign s1 = b + cc;
   assign s2 = b - cc;
   assign s3 = a - d;

   assign out0 = s0[OUT_W-1:0];
   assign out1 = s1[OUT_W-1:0];
   assign out2 = s2[OUT_W-1:0];
   assign out3 = s3[OUT_W-1:0];
endmodule

// File: rtl/itransform_4x4.sv
// VP8 inverse 4x4 transform + reconstruction; 3-stage pipeline, 1 block/clk, 3 clk latency.
// Global stall: when out_valid is held without out_ready every stage freezes and in_ready drops.
module itransform_4x4
   import vp8_tx_pkg::*;
#(
   parameter int COEF_W = DEF_COEF_W
) (
   input  logic              clk,
   input  logic              rst_n,
   itransform_4x4_if.slave   bus
);
   logic stall;
   logic adv;

   logic                  v1, v2, v3;
   logic [16*COEF_W-1:0]  coef1;
   logic [BLK_PIX_W-1:0]  pred1, pred2;
   logic [BLK_PIX_W-1:0]  recon_q;

   logic signed [TMP_W-1:0] tmp_d [NPIX];
   logic signed [TMP_W-1:0] tmp_q [NPIX];
   logic signed [ACC_W-1:0] v_d   [NPIX];
   logic [PIX_W-1:0]        recon_d [NPIX];

   assign stall        = v3 & ~bus.out_ready;
   assign adv          = ~stall;
   assign bus.in_ready = adv;
   assign bus.out_valid = v3;
   assign bus.recon     = recon_q;

   // Vertical pass: one butterfly per column, result stored column-major in tmp
   for (genvar c = 0; c < 4; c++) begin : g_vert
      idct_1d #(.IN_W(COEF_W), .OUT_W(TMP_W)) u_vert (
         .in0     ($signed(coef1[COEF_W*(c)      +: COEF_W])),
         .in1     ($signed(coef1[COEF_W*(4 + c)  +: COEF_W])),
         .in2     ($signed(coef1[COEF_W*(8 + c)  +: COEF_W])),
         .in3     ($signed(coef1[COEF_W*(12 + c) +: COEF_W])),
         .dc_bias (3'd0),
         .out0    (tmp_d[4*c + 0]),
         .out1    (tmp_d[4*c + 1]),
         .out2    (tmp_d[4*c + 2]),
         .out3    (tmp_d[4*c + 3])
      );
   end

   for (genvar r = 0; r < 4; r++) begin : g_horz
      idct_1d #(.IN_W(TMP_W), .OUT_W(ACC_W)) u_horz (
         .in0     (tmp_q[r]),
         .in1     (tmp_q[4 + r]),
         .in2     (tmp_q[8 + r]),
         .in3     (tmp_q[12 + r]),
         .dc_bias (3'd4),
         .out0    (v_d[4*r + 0]),
         .out1    (v_d[4*r + 1]),
         .out2    (v_d[4*r + 2]),
         .out3    (v_d[4*r + 3])
      );
   end

   for (genvar k = 0; k < NPIX; k++) begin : g_clip
      assign recon_d[k] = clip255(SUM_W'(v_d[k] >>> 3) + $signed(SUM_W'(pred2[PIX_W*k +: PIX_W])));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         coef1   <= '0;
         pred1   <= '0;
         pred2   <= '0;
         recon_q <= '0;
         for (int k = 0; k < NPIX; k++)
            tmp_q[k] <= '0;
      end else if (adv) begin
         v1    <= bus.in_valid;
         coef1 <= bus.coef;
         pred1 <= bus.pred;
         v2    <= v1;
         pred2 <= pred1;
         for (int k = 0; k < NPIX; k++)
            tmp_q[k] <= tmp_d[k];
         v3    <= v2;
         for (int k = 0; k < NPIX; k++)
            recon_q[PIX_W*k +: PIX_W] <= recon_d[k];
      end
   end
endmodule

// File: tb/tb_itransform_4x4.sv
// Bench for itransform_4x4: scoreboard queue fed at accept time, monitor pops on every consumed block;
// expectations come from a direct integer TransformOne model or hand-derived constants.
module tb_itransform_4x4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   itransform_4x4_if #(.COEF_W(16)) bus ();

   itransform_4x4 #(.COEF_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   logic [127:0] exp_q [$];
   logic force_stall = 1'b0;
   logic rand_rdy    = 1'b0;

   function automatic void check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endfunction

   function automatic longint mulk(input longint x, input longint k);
      return (x * k) >>> 16;
   endfunction

   // Integer rendering of the reference TransformOne followed by prediction add and clip
   function automatic logic [127:0] ref_recon(input logic [255:0] c, input logic [127:0] p);
      longint in_v [16];
      longint tmp  [16];
      longint v    [4];
      longint a, b, cc, d, dc, s;
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < 16; k++)
         in_v[k] = longint'($signed(c[16*k +: 16]));
      for (int col = 0; col < 4; col++) begin
         a  = in_v[col] + in_v[8 + col];
         b  = in_v[col] - in_v[8 + col];
         cc = mulk(in_v[4 + col], 35468) - mulk(in_v[12 + col], 85627);
         d  = mulk(in_v[4 + col], 85627) + mulk(in_v[12 + col], 35468);
         tmp[4*col + 0] = a + d;
         tmp[4*col + 1] = b + cc;
         tmp[4*col + 2] = b - cc;
         tmp[4*col + 3] = a - d;
      end
      for (int row = 0; row < 4; row++) begin
         dc = tmp[row] + 4;
         a  = dc + tmp[8 + row];
         b  = dc - tmp[8 + row];
         cc = mulk(tmp[4 + row], 35468) - mulk(tmp[12 + row], 85627);
         d  = mulk(tmp[4 + row], 85627) + mulk(tmp[12 + row], 35468);
         v[0] = a + d;
         v[1] = b + cc;
         v[2] = b - cc;
         v[3] = a - d;
         for (int col = 0; col < 4; col++) begin
            s = longint'(p[8*(4*row + col) +: 8]) + (v[col] >>> 3);
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            r[8*(4*row + col) +: 8] = 8'(s);
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] fill8(input logic [7:0] val);
      return {16{val}};
   endfunction

   function automatic logic [255:0] dc_blk(input int val);
      logic [255:0] r;
      r = '0;
      r[15:0] = 16'(val);
      return r;
   endfunction

   // Present a block, hold it until accepted, record its expected reconstruction
   task automatic send(input logic [255:0] c, input logic [127:0] p, input logic [127:0] expv);
      int guard;
      guard = 0;
      bus.in_valid = 1'b1;
      bus.coef     = c;
      bus.pred     = p;
      #1;
      while (!bus.in_ready && guard < 1000) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!bus.in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stuck at %0d for %0d cycles", bus.in_ready, guard);
      end else begin
         exp_q.push_back(expv);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      #2;
      check("drain_pending", 128'(exp_q.size()), 128'd0);
   endtask

   // Monitor: drives out_ready, checks the ready rule and pops the scoreboard on each consumed block
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         bus.out_ready = force_stall ? 1'b0 : (rand_rdy ? ($urandom_range(3) != 0) : 1'b1);
         #1;
         if (rst_n) begin
            check("in_ready_rule", 128'(bus.in_ready), 128'(!(bus.out_valid && !bus.out_ready)));
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_out: got %h with empty scoreboard", bus.recon);
               end else begin
                  check("recon", bus.recon, exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      int n;
      logic [255:0] c;
      logic [127:0] p;

      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.coef     = '0;
      bus.pred     = '0;
      #3;
      check("reset_out_valid", 128'(bus.out_valid), 128'd0);
      repeat (3) @(negedge clk);
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      #2;
      check("in_ready_after_reset", 128'(bus.in_ready), 128'd1);

      // Zero block: pass-through of prediction, and first-block latency
      send('0, fill8(8'd128), fill8(8'd128));
      n = 1;
      #1;
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("latency", 128'(n), 128'd3);
      drain();

      // DC only, plain / clip high / floor and clip low
      send(dc_blk(80),  fill8(8'd100), fill8(8'd110));
      send(dc_blk(80),  fill8(8'd250), fill8(8'd255));
      send(dc_blk(-80), fill8(8'd5),   fill8(8'd0));
      send(dc_blk(-80), fill8(8'd20),  fill8(8'd10));
      drain();

      // Back-to-back stream with a 5-cycle consumer stall in the middle
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(dc_blk(16 * i), fill8(8'd50), fill8(8'(50 + 2 * i)));
         end
         begin
            repeat (4) @(posedge clk);
            force_stall = 1'b1;
            repeat (5) @(posedge clk);
            force_stall = 1'b0;
         end
      join
      drain();

      // Reset with three blocks in flight
      force_stall = 1'b1;
      for (int i = 0; i < 3; i++)
         send(dc_blk(8 * (i + 1)), fill8(8'd77), fill8(8'd77));
      #3;
      check("inflight_valid", 128'(bus.out_valid), 128'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset_valid", 128'(bus.out_valid), 128'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      force_stall = 1'b0;
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #2;
         check("post_reset_idle", 128'(bus.out_valid), 128'd0);
      end

      // Full-range coefficients exercise the widest intermediate values
      rand_rdy = 1'b1;
      for (int i = 0; i < 200; i++) begin
         for (int k = 0; k < 16; k++)
            c[16*k +: 16] = 16'($urandom);
         p = {$urandom, $urandom, $urandom, $urandom};
         send(c, p, ref_recon(c, p));
      end

      // Random traffic, coefficients in [-2048,2047], random gaps and backpressure
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(3) == 0)
            @(negedge clk);
         for (int k = 0; k < 16; k++)
            c[16*k +: 16] = 16'(int'($urandom_range(4095)) - 2048);
         p = {$urandom, $urandom, $urandom, $urandom};
         send(c, p, ref_recon(c, p));
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
